// File: rtl/reg_scoreboard.sv
// reg_scoreboard: counts outstanding register writes between issue and writeback
// and stalls issue on RAW hazards or a saturated destination counter.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic            issue_wen,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs,
    input  logic [4:0]      issue_rt,
    input  logic            use_rs,
    input  logic            use_rt,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            stall,
    output logic            issue_fire,
    output logic [NREG-1:0] busy_mask,
    output logic            proto_err
);
    localparam logic [CNTW-1:0] MAXC = '1;
    logic [CNTW-1:0] r_cnt [NREG];
    logic [CNTW-1:0] w_nxt [NREG];
    logic [NREG-1:0] r_busy, w_inc, w_dec;
    logic            r_err, w_rs_pend, w_rt_pend, w_rd_sat, w_wb_err;
    // a writeback that empties the counter this cycle bypasses the value to issue
    always_comb begin
        w_rs_pend = issue_rs != '0 && r_cnt[issue_rs] != '0 &&
                    !(wb_valid && wb_rd == issue_rs && r_cnt[issue_rs] == CNTW'(1));
        w_rt_pend = issue_rt != '0 && r_cnt[issue_rt] != '0 &&
                    !(wb_valid && wb_rd == issue_rt && r_cnt[issue_rt] == CNTW'(1));
        w_rd_sat  = issue_wen && issue_rd != '0 && r_cnt[issue_rd] == MAXC &&
                    !(wb_valid && wb_rd == issue_rd);
        stall     = issue_valid && ((use_rs && w_rs_pend) || (use_rt && w_rt_pend) || w_rd_sat);
        issue_fire = issue_valid && !stall && !flush;
        w_wb_err  = wb_valid && !flush && wb_rd != '0 && r_cnt[wb_rd] == '0;
    end
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NREG; i++) begin
            w_inc[i] = issue_fire && issue_wen && issue_rd == 5'(i);
            w_dec[i] = wb_valid && wb_rd == 5'(i) && r_cnt[i] != '0;
        end
        for (int i = 0; i < NREG; i++)
            w_nxt[i] = flush ? '0 : r_cnt[i] + CNTW'(w_inc[i]) - CNTW'(w_dec[i]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i]  <= w_nxt[i];
                r_busy[i] <= w_nxt[i] != '0;
            end
            r_err <= r_err | w_wb_err;
        end
    end
    assign busy_mask = r_busy;
    assign proto_err = r_err;
endmodule
